// File: rtl/bitfusion_pkg.sv
// Shared types and constants for the bit-fusion dot-product sequencer.
package bitfusion_pkg;

    // Default accumulator / result width.
    localparam int ACC_W_DEF = 32;

    // Operand widths the fusion unit can be configured for.
    localparam logic [3:0] WIDTH_1 = 4'd1;
    localparam logic [3:0] WIDTH_2 = 4'd2;
    localparam logic [3:0] WIDTH_4 = 4'd4;
    localparam logic [3:0] WIDTH_8 = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when w is one of the fusion-unit operand widths.
    function automatic logic width_legal(input logic [3:0] w);
        return (w == WIDTH_1) || (w == WIDTH_2) || (w == WIDTH_4) || (w == WIDTH_8);
    endfunction

    // Low-bit mask that keeps only the bits belonging to a w-bit operand.
    function automatic logic [7:0] width_mask(input logic [3:0] w);
        logic [7:0] m;
        case (w)
            WIDTH_1: m = 8'h01;
            WIDTH_2: m = 8'h03;
            WIDTH_4: m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bitfusion_acc.sv
// Extend-and-accumulate register: widens the 16-bit fusion-unit product to
// ACC_W bits and adds it into a wrapping accumulator.
module bitfusion_acc
    import bitfusion_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic             sext_i,
    input  logic [15:0]      psum_i,
    output logic [ACC_W-1:0] acc_o
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Widen the product: sign-extend whenever either operand is signed.
    always_comb begin
        if (sext_i) begin
            ext = ACC_W'($signed(psum_i));
        end else begin
            ext = ACC_W'(psum_i);
        end
        acc_d = acc_q + ext;
    end

    // Accumulator: cleared on a new job, adds one product per valid pipe slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/bitfusion_dot_seq.sv
// Dot-product sequencer: accepts a job configuration, streams operand pairs
// into an external bit-fusion multiplier, accumulates the products and hands
// back the sum through a valid/ready result port.
module bitfusion_dot_seq
    import bitfusion_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [3:0]       cfg_in_width,
    input  logic [3:0]       cfg_weight_width,
    input  logic             cfg_s_in,
    input  logic             cfg_s_weight,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_in,
    input  logic [7:0]       op_weight,
    output logic [7:0]       fu_in,
    output logic [7:0]       fu_weight,
    output logic [3:0]       fu_in_width,
    output logic [3:0]       fu_weight_width,
    output logic             fu_s_in,
    output logic             fu_s_weight,
    input  logic [15:0]      fu_psum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_err
);

    state_e           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic             pipe_vld_q;
    logic             cfg_ready_q;
    logic             op_ready_q;
    logic             res_valid_q;
    logic             res_err_q;
    logic [7:0]       fu_in_q;
    logic [7:0]       fu_weight_q;
    logic [3:0]       fu_in_width_q;
    logic [3:0]       fu_weight_width_q;
    logic             fu_s_in_q;
    logic             fu_s_weight_q;

    logic             cfg_hs;
    logic             op_hs;
    logic             res_hs;
    logic             cfg_legal;
    logic [ACC_W-1:0] acc_sum;

    // Handshakes and derived control terms.
    always_comb begin
        cfg_hs    = cfg_valid & cfg_ready_q;
        op_hs     = op_valid & op_ready_q;
        res_hs    = res_valid_q & res_ready;
        cfg_legal = width_legal(cfg_in_width) & width_legal(cfg_weight_width);
        cnt_d     = cnt_q + LEN_W'(1);
    end

    // Job FSM with registered handshake outputs, issue counter and operand
    // registers. The last issue leaves RUN so op_ready drops in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            len_q             <= '0;
            cnt_q             <= '0;
            pipe_vld_q        <= 1'b0;
            cfg_ready_q       <= 1'b1;
            op_ready_q        <= 1'b0;
            res_valid_q       <= 1'b0;
            res_err_q         <= 1'b0;
            fu_in_q           <= '0;
            fu_weight_q       <= '0;
            fu_in_width_q     <= WIDTH_8;
            fu_weight_width_q <= WIDTH_8;
            fu_s_in_q         <= 1'b0;
            fu_s_weight_q     <= 1'b0;
        end else begin
            pipe_vld_q <= op_hs;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_hs) begin
                        len_q       <= cfg_len;
                        cnt_q       <= '0;
                        cfg_ready_q <= 1'b0;
                        if (!cfg_legal) begin
                            state_q     <= ST_DONE;
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b1;
                        end else if (cfg_len == '0) begin
                            state_q     <= ST_DONE;
                            res_valid_q <= 1'b1;
                            res_err_q   <= 1'b0;
                        end else begin
                            state_q           <= ST_RUN;
                            op_ready_q        <= 1'b1;
                            fu_in_width_q     <= cfg_in_width;
                            fu_weight_width_q <= cfg_weight_width;
                            fu_s_in_q         <= cfg_s_in;
                            fu_s_weight_q     <= cfg_s_weight;
                        end
                    end
                end
                ST_RUN: begin
                    if (op_hs) begin
                        fu_in_q     <= op_in & width_mask(fu_in_width_q);
                        fu_weight_q <= op_weight & width_mask(fu_weight_width_q);
                        cnt_q       <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q    <= ST_DRAIN;
                            op_ready_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q     <= ST_DONE;
                    res_valid_q <= 1'b1;
                    res_err_q   <= 1'b0;
                end
                ST_DONE: begin
                    if (res_hs) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cfg_ready_q <= 1'b1;
                    op_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    res_err_q   <= 1'b0;
                end
            endcase
        end
    end

    bitfusion_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cfg_hs),
        .add_i  (pipe_vld_q),
        .sext_i (fu_s_in_q | fu_s_weight_q),
        .psum_i (fu_psum),
        .acc_o  (acc_sum)
    );

    assign cfg_ready       = cfg_ready_q;
    assign op_ready        = op_ready_q;
    assign res_valid       = res_valid_q;
    assign res_err         = res_err_q;
    // The accumulator is quiet in DONE, so it can be presented directly.
    assign res_data        = res_valid_q ? acc_sum : '0;
    assign fu_in           = fu_in_q;
    assign fu_weight       = fu_weight_q;
    assign fu_in_width     = fu_in_width_q;
    assign fu_weight_width = fu_weight_width_q;
    assign fu_s_in         = fu_s_in_q;
    assign fu_s_weight     = fu_s_weight_q;

endmodule

// File: tb/tb_bitfusion_dot_seq.sv
// Scoreboard bench for bitfusion_dot_seq with a behavioural fusion multiplier.
module tb_bitfusion_dot_seq;

    localparam int LEN_W = 8;
    localparam int ACC_W = 32;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [LEN_W-1:0] cfg_len;
    logic [3:0]       cfg_in_width;
    logic [3:0]       cfg_weight_width;
    logic             cfg_s_in;
    logic             cfg_s_weight;
    logic             op_valid;
    logic             op_ready;
    logic [7:0]       op_in;
    logic [7:0]       op_weight;
    logic [7:0]       fu_in;
    logic [7:0]       fu_weight;
    logic [3:0]       fu_in_width;
    logic [3:0]       fu_weight_width;
    logic             fu_s_in;
    logic             fu_s_weight;
    logic [15:0]      fu_psum;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_err;

    bitfusion_dot_seq #(
        .LEN_W (LEN_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_len          (cfg_len),
        .cfg_in_width     (cfg_in_width),
        .cfg_weight_width (cfg_weight_width),
        .cfg_s_in         (cfg_s_in),
        .cfg_s_weight     (cfg_s_weight),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_in            (op_in),
        .op_weight        (op_weight),
        .fu_in            (fu_in),
        .fu_weight        (fu_weight),
        .fu_in_width      (fu_in_width),
        .fu_weight_width  (fu_weight_width),
        .fu_s_in          (fu_s_in),
        .fu_s_weight      (fu_s_weight),
        .fu_psum          (fu_psum),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_err          (res_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fusion-unit stand-in: multiplies the presented bytes as given, treating
    // bit (width-1) as the sign when the operand is signed.
    int fa, fb, fp;
    always_comb begin
        fa = int'(fu_in);
        fb = int'(fu_weight);
        if (fu_s_in && fu_in_width >= 4'd1 && fu_in_width <= 4'd8
            && ((fa >> (int'(fu_in_width) - 1)) & 1) == 1)
            fa = fa - (1 << int'(fu_in_width));
        if (fu_s_weight && fu_weight_width >= 4'd1 && fu_weight_width <= 4'd8
            && ((fb >> (int'(fu_weight_width) - 1)) & 1) == 1)
            fb = fb - (1 << int'(fu_weight_width));
        fp = fa * fb;
        fu_psum = fp[15:0];
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          nops;
    } exp_t;

    exp_t sb_q[$];
    int   ops_seen = 0;

    logic [7:0] opa [0:15];
    logic [7:0] opb [0:15];

    localparam logic [63:0] RST_OUTS = {2'b00, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0,
                                        8'd0, 8'd0, 4'd8, 4'd8, 1'b0, 1'b0};

    function automatic logic [63:0] outs();
        return {2'b00, cfg_ready, op_ready, res_valid, res_data, res_err,
                fu_in, fu_weight, fu_in_width, fu_weight_width, fu_s_in, fu_s_weight};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Numeric value of a w-bit operand taken from the low bits of raw.
    function automatic longint val(input logic [7:0] raw, input logic [3:0] w, input logic s);
        longint m;
        longint span;
        span = longint'(1) << w;
        m = longint'(raw) % span;
        if (s && m >= (span / 2)) m = m - span;
        return m;
    endfunction

    function automatic logic legal_w(input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
    endfunction

    // Monitor: every cycle a result is shown it must match the queue head;
    // the head is retired on the result handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (op_valid && op_ready) ops_seen++;
            if (res_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_res_valid", {63'd0, res_valid}, 64'd0);
                end else begin
                    check("res_data", {32'd0, res_data}, {32'd0, sb_q[0].data});
                    check("res_err", {63'd0, res_err}, {63'd0, sb_q[0].err});
                    if (res_ready) begin
                        check("ops_consumed", 64'(ops_seen), 64'(sb_q[0].nops));
                        void'(sb_q.pop_front());
                        ops_seen = 0;
                    end
                end
            end
        end
    end

    // One complete job: configure, stream opa/opb, wait, optionally stall the
    // result, then accept it. Called at posedge+1.
    task automatic run_job(input int len, input logic [3:0] iw, input logic [3:0] ww,
                           input logic si, input logic sw, input int gap_pct,
                           input int stall, input logic measure,
                           input logic use_const, input logic [31:0] cexp);
        exp_t   e;
        longint sum;
        logic   hs;
        logic   done;
        int     idx, guard, cyc;
        sum = 0;
        e.err = !(legal_w(iw) && legal_w(ww));
        if (!e.err)
            for (int i = 0; i < len; i++) sum += val(opa[i], iw, si) * val(opb[i], ww, sw);
        e.data = e.err ? 32'd0 : (use_const ? cexp : sum[31:0]);
        e.nops = e.err ? 0 : len;

        cfg_len = LEN_W'(len);
        cfg_in_width = iw;
        cfg_weight_width = ww;
        cfg_s_in = si;
        cfg_s_weight = sw;
        cfg_valid = 1'b1;
        done = 1'b0;
        guard = 0;
        while (!done && guard < 50) begin
            hs = cfg_ready;
            @(posedge clk);
            #1;
            guard++;
            if (hs) done = 1'b1;
        end
        check("cfg_accept", {63'd0, done}, 64'd1);
        if (done) sb_q.push_back(e);
        cfg_valid = 1'b0;
        cfg_len = LEN_W'($urandom);
        cfg_in_width = 4'($urandom);

        cyc = 0;
        if (!e.err && len > 0) begin
            idx = 0;
            guard = 0;
            while (idx < len && guard < 2000) begin
                op_valid = ($urandom_range(99) >= gap_pct);
                if (op_valid) begin
                    op_in = opa[idx];
                    op_weight = opb[idx];
                end else begin
                    op_in = 8'($urandom);
                    op_weight = 8'($urandom);
                end
                hs = op_valid && op_ready;
                @(posedge clk);
                #1;
                cyc++;
                guard++;
                if (hs) idx++;
            end
            check("ops_issued", 64'(idx), 64'(len));
            op_valid = 1'b0;
        end else begin
            op_valid = 1'b1;
            op_in = 8'($urandom);
            op_weight = 8'($urandom);
        end

        guard = 0;
        while (!res_valid && guard < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            guard++;
        end
        check("res_valid_seen", {63'd0, res_valid}, 64'd1);
        if (measure) check("latency_edges", 64'(cyc), 64'(len + 1));

        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        op_valid = 1'b0;
        check("back_to_idle", {63'd0, cfg_ready}, 64'd1);
    endtask

    // Start a job, issue two operands, then hit reset in the middle of RUN.
    task automatic reset_mid_run();
        logic hs;
        for (int i = 0; i < 6; i++) begin
            opa[i] = 8'($urandom);
            opb[i] = 8'($urandom);
        end
        cfg_len = 8'd6;
        cfg_in_width = 4'd4;
        cfg_weight_width = 4'd2;
        cfg_s_in = 1'b1;
        cfg_s_weight = 1'b1;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        op_valid = 1'b1;
        op_in = 8'h7F;
        op_weight = 8'h03;
        repeat (2) begin
            hs = op_ready;
            @(posedge clk);
            #1;
        end
        check("mid_run_busy", {63'd0, op_ready}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_run_outputs", outs(), RST_OUTS);
        sb_q.delete();
        ops_seen = 0;
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("post_reset_no_result", {63'd0, res_valid}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pw [0:3];
        logic [3:0] iw, ww;
        int         len;
        pw[0] = 4'd1; pw[1] = 4'd2; pw[2] = 4'd4; pw[3] = 4'd8;

        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_len = '0;
        cfg_in_width = 4'd8;
        cfg_weight_width = 4'd8;
        cfg_s_in = 1'b0;
        cfg_s_weight = 1'b0;
        op_valid = 1'b0;
        op_in = '0;
        op_weight = '0;
        res_ready = 1'b0;
        #1;
        check("reset_outputs", outs(), RST_OUTS);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned 8x8, three pairs, no gaps: latency and value.
        opa[0] = 8'd255; opb[0] = 8'd255;
        opa[1] = 8'd1;   opb[1] = 8'd2;
        opa[2] = 8'd0;   opb[2] = 8'd9;
        run_job(3, 4'd8, 4'd8, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 32'd65027);

        // Signed 4x4 with garbage in the upper nibbles: (-8,7),(-8,-8).
        opa[0] = 8'hF8; opb[0] = 8'h07;
        opa[1] = 8'h58; opb[1] = 8'h38;
        run_job(2, 4'd4, 4'd4, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 32'd8);

        // Signed 8x2: (-128,-2).
        opa[0] = 8'h80; opb[0] = 8'hFE;
        run_job(1, 4'd8, 4'd2, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 32'd256);

        // Unsigned input, signed weight: (255,-128).
        opa[0] = 8'hFF; opb[0] = 8'h80;
        run_job(1, 4'd8, 4'd8, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 32'hFFFF8080);

        // Illegal width, then empty job.
        run_job(4, 4'd3, 4'd8, 1'b0, 1'b0, 0, 3, 1'b0, 1'b1, 32'd0);
        run_job(0, 4'd8, 4'd8, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 32'd0);

        // Operand gaps and a ten-cycle result stall.
        for (int i = 0; i < 10; i++) begin
            opa[i] = 8'($urandom);
            opb[i] = 8'($urandom);
        end
        run_job(10, 4'd8, 4'd4, 1'b1, 1'b0, 40, 10, 1'b0, 1'b0, 32'd0);

        // Randomized jobs.
        for (int j = 0; j < 20; j++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < 16; i++) begin
                opa[i] = 8'($urandom);
                opb[i] = 8'($urandom);
            end
            iw = pw[$urandom_range(3)];
            ww = pw[$urandom_range(3)];
            if ($urandom_range(7) == 0) iw = 4'($urandom);
            run_job(len, iw, ww, 1'($urandom), 1'($urandom), 30,
                    $urandom_range(0, 10), 1'b0, 1'b0, 32'd0);
        end

        // Reset in the middle of a job, then a clean job afterwards.
        reset_mid_run();
        opa[0] = 8'd200; opb[0] = 8'd3;
        opa[1] = 8'd17;  opb[1] = 8'd11;
        run_job(2, 4'd8, 4'd8, 1'b0, 1'b0, 0, 2, 1'b1, 1'b1, 32'd787);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
